// File: rtl/ysyx_23060203_clint_mh.sv
// Multi-hart CLINT: prescaled 64-bit mtime, per-hart mtimecmp/msip, AXI-lite style read/write slave.
// Optional YSYX_23060203_CLINT_MTIME_SNAP_EN: low-word mtime read latches the high word for a tear-free read.

module ysyx_23060203_clint_hart (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mtime_i,
  input  logic        sip_we_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] wmask_i,
  output logic [63:0] mtimecmp_o,
  output logic        msip_o,
  output logic        mtip_o
);
  logic [63:0] cmp_q, cmp_d;
  logic        sip_q, sip_d, tip_q;

  always_comb begin
    cmp_d = cmp_q;
    sip_d = sip_q;
    if (cmp_lo_we_i) cmp_d[31:0]  = (cmp_q[31:0]  & ~wmask_i) | (wdata_i & wmask_i);
    if (cmp_hi_we_i) cmp_d[63:32] = (cmp_q[63:32] & ~wmask_i) | (wdata_i & wmask_i);
    if (sip_we_i && wmask_i[0]) sip_d = wdata_i[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmp_q <= '1;
      sip_q <= 1'b0;
      tip_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      sip_q <= sip_d;
      // Compare against the registered values: one cycle of latency after either side changes.
      tip_q <= (mtime_i >= cmp_q);
    end
  end

  assign mtimecmp_o = cmp_q;
  assign msip_o     = sip_q;
  assign mtip_o     = tip_q;
endmodule

module ysyx_23060203_clint_mh #(
  parameter int HARTS    = 1,
  parameter int TICK_DIV = 1,
  parameter int ID_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [HARTS-1:0]  mtip_o,
  output logic [HARTS-1:0]  msip_o,
  input  logic              read_arvalid_i,
  output logic              read_arready_o,
  input  logic [31:0]       read_araddr_i,
  input  logic [ID_W-1:0]   read_arid_i,
  output logic              read_rvalid_o,
  input  logic              read_rready_i,
  output logic [31:0]       read_rdata_o,
  output logic [1:0]        read_rresp_o,
  output logic              read_rlast_o,
  output logic [ID_W-1:0]   read_rid_o,
  input  logic              write_awvalid_i,
  output logic              write_awready_o,
  input  logic [31:0]       write_awaddr_i,
  input  logic [ID_W-1:0]   write_awid_i,
  input  logic              write_wvalid_i,
  output logic              write_wready_o,
  input  logic [31:0]       write_wdata_i,
  input  logic [3:0]        write_wstrb_i,
  output logic              write_bvalid_o,
  input  logic              write_bready_i,
  output logic [1:0]        write_bresp_o,
  output logic [ID_W-1:0]   write_bid_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic       hit;
    logic       sip;
    logic       cmp_lo;
    logic       cmp_hi;
    logic       mt_lo;
    logic       mt_hi;
    logic [3:0] hart;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] a);
    dec_t d;
    d = '0;
    if (a[1:0] == 2'b00) begin
      if (a[15:6] == 10'h0 && int'(a[5:2]) < HARTS) begin
        d.sip  = 1'b1;
        d.hart = a[5:2];
      end else if (a[15:7] == 9'h080 && int'(a[6:3]) < HARTS) begin
        d.cmp_lo = ~a[2];
        d.cmp_hi = a[2];
        d.hart   = a[6:3];
      end else if (a == 16'hBFF8) begin
        d.mt_lo = 1'b1;
      end else if (a == 16'hBFFC) begin
        d.mt_hi = 1'b1;
      end
    end
    d.hit = d.sip | d.cmp_lo | d.cmp_hi | d.mt_lo | d.mt_hi;
    return d;
  endfunction

  logic [63:0]             mtime_q, mtime_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [HARTS-1:0][63:0]  cmp_w;
  dec_t                    rd_dec, wr_dec;
  logic                    ar_fire, aw_fire;
  logic [31:0]             wmask, rdata_d, mt_hi_rd;
  logic                    rvalid_q, bvalid_q;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q, bresp_q;
  logic [ID_W-1:0]         rid_q, bid_q;
  logic                    unused_addr;

  assign unused_addr = ^{read_araddr_i[31:16], write_awaddr_i[31:16]};

  assign rd_dec  = decode(read_araddr_i[15:0]);
  assign wr_dec  = decode(write_awaddr_i[15:0]);
  assign ar_fire = read_arvalid_i & ~rvalid_q;
  assign aw_fire = write_awvalid_i & write_wvalid_i & ~bvalid_q;
  assign wmask   = {{8{write_wstrb_i[3]}}, {8{write_wstrb_i[2]}},
                    {8{write_wstrb_i[1]}}, {8{write_wstrb_i[0]}}};

  // Prescaler and mtime; a write suppresses that cycle's increment on all bytes.
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    mtime_d = mtime_q + {63'd0, tick};
    if (aw_fire && wr_dec.mt_lo)
      mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (write_wdata_i & wmask)};
    if (aw_fire && wr_dec.mt_hi)
      mtime_d = {(mtime_q[63:32] & ~wmask) | (write_wdata_i & wmask), mtime_q[31:0]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q <= '0;
      presc_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
    end
  end

  for (genvar h = 0; h < HARTS; h++) begin : g_hart
    logic sel;
    assign sel = aw_fire && (wr_dec.hart == 4'(h));
    ysyx_23060203_clint_hart u_hart (
      .clock       (clock),
      .reset       (reset),
      .mtime_i     (mtime_q),
      .sip_we_i    (sel && wr_dec.sip),
      .cmp_lo_we_i (sel && wr_dec.cmp_lo),
      .cmp_hi_we_i (sel && wr_dec.cmp_hi),
      .wdata_i     (write_wdata_i),
      .wmask_i     (wmask),
      .mtimecmp_o  (cmp_w[h]),
      .msip_o      (msip_o[h]),
      .mtip_o      (mtip_o[h])
    );
  end

`ifdef YSYX_23060203_CLINT_MTIME_SNAP_EN
  logic [31:0] snap_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        snap_q <= '0;
    else if (ar_fire && rd_dec.mt_lo) snap_q <= mtime_q[63:32];
  end
  assign mt_hi_rd = snap_q;
`else
  assign mt_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rdata_d = '0;
    for (int h = 0; h < HARTS; h++) begin
      if (rd_dec.hart == 4'(h)) begin
        if (rd_dec.sip)    rdata_d = {31'd0, msip_o[h]};
        if (rd_dec.cmp_lo) rdata_d = cmp_w[h][31:0];
        if (rd_dec.cmp_hi) rdata_d = cmp_w[h][63:32];
      end
    end
    if (rd_dec.mt_lo) rdata_d = mtime_q[31:0];
    if (rd_dec.mt_hi) rdata_d = mt_hi_rd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rid_q    <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rd_dec.hit ? 2'b00 : 2'b10;
      rid_q    <= read_arid_i;
    end else if (read_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
    end else if (aw_fire) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_dec.hit ? 2'b00 : 2'b10;
      bid_q    <= write_awid_i;
    end else if (write_bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  assign read_arready_o  = ~rvalid_q;
  assign read_rvalid_o   = rvalid_q;
  assign read_rdata_o    = rdata_q;
  assign read_rresp_o    = rresp_q;
  assign read_rlast_o    = 1'b1;
  assign read_rid_o      = rid_q;
  assign write_awready_o = aw_fire;
  assign write_wready_o  = aw_fire;
  assign write_bvalid_o  = bvalid_q;
  assign write_bresp_o   = bresp_q;
  assign write_bid_o     = bid_q;
endmodule

// File: tb/tb_ysyx_23060203_clint_mh.sv
// Randomized scoreboard bench for the multi-hart CLINT against a cycle-level behavioural model.
module tb_ysyx_23060203_clint_mh;
  localparam int HARTS = 2;
  localparam int TDIV  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [HARTS-1:0] mtip, msip;
  logic        arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] araddr = 0, rdata;
  logic [3:0]  arid = 0, rid;
  logic [1:0]  rresp;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic [31:0] awaddr = 0, wdata = 0;
  logic [3:0]  wstrb = 0, awid = 0, bid;
  logic [1:0]  bresp;

  always #5 clock = ~clock;

  ysyx_23060203_clint_mh #(.HARTS(HARTS), .TICK_DIV(TDIV), .ID_W(4)) dut (
    .clock(clock), .reset(reset), .mtip_o(mtip), .msip_o(msip),
    .read_arvalid_i(arvalid), .read_arready_o(arready), .read_araddr_i(araddr),
    .read_arid_i(arid), .read_rvalid_o(rvalid), .read_rready_i(rready),
    .read_rdata_o(rdata), .read_rresp_o(rresp), .read_rlast_o(rlast), .read_rid_o(rid),
    .write_awvalid_i(awvalid), .write_awready_o(awready), .write_awaddr_i(awaddr),
    .write_awid_i(awid), .write_wvalid_i(wvalid), .write_wready_o(wready),
    .write_wdata_i(wdata), .write_wstrb_i(wstrb), .write_bvalid_o(bvalid),
    .write_bready_i(bready), .write_bresp_o(bresp), .write_bid_o(bid)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; logic [3:0] id; } rexp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  int n_chk = 0, n_pass = 0;

  // Reference state: what the registers hold after the next clock edge once tick() has run.
  int unsigned      m_c;
  logic [63:0]      m_mtime;
  logic [31:0]      m_snap;
  logic [63:0]      m_cmp [HARTS];
  logic [HARTS-1:0] m_msip, m_mtip;
  logic             m_rpend, m_bpend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else if (n_chk - n_pass <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_c = 0; m_mtime = '0; m_snap = '0; m_msip = '0; m_mtip = '0;
    m_rpend = 0; m_bpend = 0;
    for (int h = 0; h < HARTS; h++) m_cmp[h] = '1;
    rq.delete(); bq.delete();
  endtask

  function automatic void m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int o;
    o = int'(a[15:0]);
    d = '0; r = 2'b10;
    for (int h = 0; h < HARTS; h++) begin
      if (o == 4*h)            begin d = {31'd0, m_msip[h]}; r = 2'b00; end
      if (o == 'h4000 + 8*h)   begin d = m_cmp[h][31:0];     r = 2'b00; end
      if (o == 'h4004 + 8*h)   begin d = m_cmp[h][63:32];    r = 2'b00; end
    end
    if (o == 'hBFF8) begin d = m_mtime[31:0]; r = 2'b00; end
    if (o == 'hBFFC) begin
`ifdef YSYX_23060203_CLINT_MTIME_SNAP_EN
      d = m_snap;
`else
      d = m_mtime[63:32];
`endif
      r = 2'b00;
    end
  endfunction

  // Advance the model across the coming rising edge using the inputs now driven, then wait a cycle.
  task automatic tick();
    if (reset) m_reset();
    else begin
      logic ar_acc, aw_acc;
      logic [63:0] nxt;
      logic [HARTS-1:0] tip;
      rexp_t re;
      bexp_t be;
      int o;
      ar_acc = arvalid && !m_rpend;
      aw_acc = awvalid && wvalid && !m_bpend;
      for (int h = 0; h < HARTS; h++) tip[h] = (m_mtime >= m_cmp[h]);
      if (ar_acc) begin
        m_read(araddr, re.data, re.resp);
        re.id = arid;
        rq.push_back(re);
`ifdef YSYX_23060203_CLINT_MTIME_SNAP_EN
        if (araddr[15:0] == 16'hBFF8) m_snap = m_mtime[63:32];
`endif
      end
      nxt = m_mtime + (((m_c % TDIV) == TDIV - 1) ? 64'd1 : 64'd0);
      if (aw_acc) begin
        o = int'(awaddr[15:0]);
        be.resp = 2'b10; be.id = awid;
        for (int h = 0; h < HARTS; h++) begin
          if (o == 4*h) begin be.resp = 2'b00; if (wstrb[0]) m_msip[h] = wdata[0]; end
          if (o == 'h4000 + 8*h) begin be.resp = 2'b00; m_cmp[h][31:0]  = bmerge(m_cmp[h][31:0], wdata, wstrb); end
          if (o == 'h4004 + 8*h) begin be.resp = 2'b00; m_cmp[h][63:32] = bmerge(m_cmp[h][63:32], wdata, wstrb); end
        end
        if (o == 'hBFF8) begin be.resp = 2'b00; nxt = {m_mtime[63:32], bmerge(m_mtime[31:0], wdata, wstrb)}; end
        if (o == 'hBFFC) begin be.resp = 2'b00; nxt = {bmerge(m_mtime[63:32], wdata, wstrb), m_mtime[31:0]}; end
        bq.push_back(be);
      end
      if (ar_acc) m_rpend = 1; else if (rready) m_rpend = 0;
      if (aw_acc) m_bpend = 1; else if (bready) m_bpend = 0;
      m_mtime = nxt;
      m_mtip  = tip;
      m_c++;
    end
    @(negedge clock);
  endtask

  task automatic rd(input logic [15:0] o);
    int n = 0;
    rready = 1;
    while (m_rpend && n < 20) begin tick(); n++; end
    if (m_rpend) fail("rd_wait_timeout");
    arvalid = 1; araddr = {16'($urandom), o}; arid = 4'($urandom);
    tick();
    arvalid = 0;
  endtask

  task automatic wr(input logic [15:0] o, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (m_bpend && n < 20) begin bready = 1; tick(); n++; end
    if (m_bpend) fail("wr_wait_timeout");
    awvalid = 1; wvalid = 1; awaddr = {16'h0, o}; wdata = d; wstrb = s; awid = 4'($urandom);
    tick();
    awvalid = 0; wvalid = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [15:0] o;
    case ($urandom_range(0, 12))
      0: o = 16'h0000;  1: o = 16'h0004;  2: o = 16'h0008;  3: o = 16'h4000;
      4: o = 16'h4004;  5: o = 16'h4008;  6: o = 16'h400C;  7: o = 16'h4010;
      8: o = 16'hBFF8;  9: o = 16'hBFFC;  10: o = 16'h8000; 11: o = 16'h0002;
      default: o = 16'($urandom);
    endcase
    return {16'($urandom), o};
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return m_mtime[31:0] + 32'($urandom_range(0, 30));
      default: return $urandom;
    endcase
  endfunction

  // Interrupt lines and response-valid flags, sampled shortly after each rising edge.
  initial forever begin
    @(posedge clock); #2;
    if (!reset) begin
      chk("rvalid", rvalid, m_rpend);
      chk("bvalid", bvalid, m_bpend);
      chk("mtip", mtip, m_mtip);
      chk("msip", msip, m_msip);
    end
  end

  // Response scoreboard: compare while valid is held, retire on the handshake.
  initial forever begin
    @(negedge clock); #1;
    if (!reset) begin
      chk("arready", arready, !rvalid);
      if (rvalid) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          chk("rdata", rdata, rq[0].data);
          chk("rresp", rresp, rq[0].resp);
          chk("rid", rid, rq[0].id);
          chk("rlast", rlast, 1'b1);
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          chk("bresp", bresp, bq[0].resp);
          chk("bid", bid, bq[0].id);
          if (bready) void'(bq.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ar_hold, aw_hold;
    ar_hold = 0; aw_hold = 0;
    m_reset();
    repeat (3) @(negedge clock);
    chk("rst_arready", arready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_mtip", mtip, '0);
    chk("rst_msip", msip, '0);
    reset = 0; rready = 1; bready = 1;
    repeat (9) tick();
    rd(16'hBFF8);
    rd(16'hBFFC);

    // Hart 1 timer crossing, then cleared by pushing the compare high word up.
    wr(16'h4008, 32'h40, 4'hF);
    wr(16'h400C, 32'h0, 4'hF);
    repeat (300) tick();
    rd(16'h4008);
    wr(16'h400C, 32'hFFFF_FFFF, 4'hF);
    repeat (3) tick();

    wr(16'h0004, 32'h1, 4'b0001);
    repeat (2) tick();
    wr(16'h0004, 32'h0, 4'b0000);
    rd(16'h0004);

    // Carry across the low word: high word read after the increment.
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd(16'hBFF8);
    repeat (5) tick();
    rd(16'hBFFC);
    wr(16'hBFF8, 32'h1234_5678, 4'b0101);

    // Hold rready low and let the monitor see stable data with arready low.
    repeat (2) tick();
    rready = 0; arvalid = 1; araddr = 32'h0000_BFF8; arid = 4'hA;
    tick();
    arvalid = 0;
    repeat (5) tick();
    rready = 1;
    repeat (2) tick();

    rd(16'h8000);
    wr(16'h4010, 32'h0, 4'hF);
    rd(16'h4000);
    rd(16'h400C);
    repeat (2) tick();

    repeat (700) begin
      rready = ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
      if (!ar_hold) begin
        arvalid = ($urandom_range(0, 1) == 0); araddr = pick_addr(); arid = 4'($urandom);
      end
      if (!aw_hold) begin
        awvalid = ($urandom_range(0, 2) == 0); wvalid = awvalid;
        awaddr = pick_addr(); wdata = pick_data(); awid = 4'($urandom);
        wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      ar_hold = arvalid && m_rpend;
      aw_hold = awvalid && m_bpend;
      tick();
    end
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    repeat (4) tick();

    // Reset while a write response is outstanding.
    wr(16'h0000, 32'h1, 4'hF);
    bready = 0;
    tick();
    reset = 1;
    #1;
    chk("rst_mid_bvalid", bvalid, 1'b0);
    chk("rst_mid_msip", msip, '0);
    m_reset();
    repeat (2) tick();
    reset = 0; bready = 1;
    repeat (5) tick();
    rd(16'hBFF8);
    rd(16'h0000);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
